// File: rtl/msx_layout_sequencer_pkg.sv
// Shared MSX machine types used by the layout sequencer and slot decoder.
// Config-table entries, block table, slot map and SDRAM block geometry.
package msx_layout_sequencer_pkg;

  localparam int MAX_ENTRIES  = 16;
  localparam int SDRAM_BLOCKS = 2048;
  localparam int BLOCK_SHIFT  = 14;

  typedef enum logic [4:0] {
    CONFIG_NONE       = 5'd0,
    CONFIG_RAM        = 5'd1,
    CONFIG_RAM_MAPPER = 5'd2,
    CONFIG_BIOS       = 5'd3,
    CONFIG_FDC        = 5'd4,
    CONFIG_CART_A     = 5'd5,
    CONFIG_CART_B     = 5'd6,
    CONFIG_KBD_LAYOUT = 5'd7,
    CONFIG_ROM_MIRROR = 5'd8,
    CONFIG_IO_MIRROR  = 5'd9,
    CONFIG_MIRROR     = 5'd10
  } config_typ_t;

  typedef enum logic [3:0] {
    SLOT_TYP_NONE   = 4'd0,
    SLOT_TYP_RAM    = 4'd1,
    SLOT_TYP_MAPPER = 4'd2,
    SLOT_TYP_ROM    = 4'd3,
    SLOT_TYP_FDC    = 4'd4,
    SLOT_TYP_CART_A = 4'd5,
    SLOT_TYP_CART_B = 4'd6
  } slot_typ_t;

  typedef struct packed {
    config_typ_t typ;
    logic [3:0]  reference;
    logic [7:0]  block_count;
    logic [1:0]  slot;
    logic [1:0]  sub_slot;
    logic [1:0]  start_block;
    logic [27:0] store_address;
  } msx_config_t;

  typedef struct packed {
    logic [9:0]  block_count;
    logic [24:0] offset;
  } block_t;

  typedef struct packed {
    slot_typ_t  typ;
    logic [3:0] block_id;
    logic [1:0] offset;
  } mem_block_t;

  function automatic slot_typ_t cfg2slot_typ(
    input config_typ_t t
  );
    slot_typ_t r;
    case (t)
      CONFIG_RAM:        r = SLOT_TYP_RAM;
      CONFIG_RAM_MAPPER: r = SLOT_TYP_MAPPER;
      CONFIG_BIOS,
      CONFIG_KBD_LAYOUT,
      CONFIG_ROM_MIRROR,
      CONFIG_IO_MIRROR,
      CONFIG_MIRROR:     r = SLOT_TYP_ROM;
      CONFIG_FDC:        r = SLOT_TYP_FDC;
      CONFIG_CART_A:     r = SLOT_TYP_CART_A;
      CONFIG_CART_B:     r = SLOT_TYP_CART_B;
      default:           r = SLOT_TYP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/msx_layout_sequencer_if.sv
// Bus bundle of the layout sequencer: config BRAM read, DMA request,
// slot-map and block-table write ports.
interface msx_layout_sequencer_if;

  logic [3:0]  cfg_addr;
  logic [4:0]  cfg_typ;
  logic [3:0]  cfg_reference;
  logic [7:0]  cfg_block_count;
  logic [1:0]  cfg_slot;
  logic [1:0]  cfg_sub_slot;
  logic [1:0]  cfg_start_block;
  logic [27:0] cfg_store_address;

  logic        dma_req;
  logic [27:0] dma_src;
  logic [24:0] dma_dst;
  logic [21:0] dma_len;
  logic        dma_ack;

  logic        map_we;
  logic [1:0]  map_slot;
  logic [1:0]  map_sub;
  logic [1:0]  map_page;
  logic [3:0]  map_typ;
  logic [3:0]  map_block_id;
  logic [1:0]  map_offset;

  logic        blk_we;
  logic [3:0]  blk_ref;
  logic [9:0]  blk_count;
  logic [24:0] blk_offset;

  modport seq (
    output cfg_addr,
    input  cfg_typ, cfg_reference,
    input  cfg_block_count, cfg_slot,
    input  cfg_sub_slot, cfg_start_block,
    input  cfg_store_address,
    output dma_req, dma_src,
    output dma_dst, dma_len,
    input  dma_ack,
    output map_we, map_slot, map_sub,
    output map_page, map_typ,
    output map_block_id, map_offset,
    output blk_we, blk_ref,
    output blk_count, blk_offset
  );

  modport env (
    input  cfg_addr,
    output cfg_typ, cfg_reference,
    output cfg_block_count, cfg_slot,
    output cfg_sub_slot, cfg_start_block,
    output cfg_store_address,
    input  dma_req, dma_src,
    input  dma_dst, dma_len,
    output dma_ack,
    input  map_we, map_slot, map_sub,
    input  map_page, map_typ,
    input  map_block_id, map_offset,
    input  blk_we, blk_ref,
    input  blk_count, blk_offset
  );

endinterface

// File: rtl/msx_layout_sequencer.sv
// Walks the config table once per load, allocating SDRAM blocks,
// filling block table / slot map and scheduling DDR3 copies.
module msx_layout_sequencer
  import msx_layout_sequencer_pkg::*;
#(
  parameter int MAX_ENTRIES  = 16,
  parameter int SDRAM_BLOCKS = 2048
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  msx_layout_sequencer_if.seq bus,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ALLOC,
    S_MAP,
    S_DMA,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      st;
  logic [3:0]  idx;
  logic [11:0] alloc;
  logic [11:0] base;
  msx_config_t ent;

  logic        alloc_typ;
  logic        mirror_typ;
  logic        dma_typ;
  logic [12:0] alloc_sum;
  logic        overflow;
  logic [8:0]  end_page;
  logic [1:0]  last_page;

  always_comb begin
    alloc_typ  = 1'b0;
    mirror_typ = 1'b0;
    dma_typ    = 1'b0;
    case (ent.typ)
      CONFIG_RAM,
      CONFIG_RAM_MAPPER: alloc_typ = 1'b1;
      CONFIG_BIOS,
      CONFIG_FDC,
      CONFIG_CART_A,
      CONFIG_CART_B: begin
        alloc_typ = 1'b1;
        dma_typ   = 1'b1;
      end
      CONFIG_KBD_LAYOUT,
      CONFIG_ROM_MIRROR,
      CONFIG_IO_MIRROR,
      CONFIG_MIRROR: mirror_typ = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alloc_sum = {1'b0, alloc}
              + {5'b0, ent.block_count};
    overflow  = alloc_sum > 13'(SDRAM_BLOCKS);
    end_page  = {7'b0, ent.start_block}
              + {1'b0, ent.block_count}
              - 9'd1;
    // zero-length mirrors still get one slot-map write
    if (ent.block_count == 8'd0)
      last_page = ent.start_block;
    else if (end_page >= 9'd3)
      last_page = 2'd3;
    else
      last_page = end_page[1:0];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st               <= S_IDLE;
      idx              <= '0;
      alloc            <= '0;
      base             <= '0;
      ent              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      bus.cfg_addr     <= '0;
      bus.dma_req      <= 1'b0;
      bus.dma_src      <= '0;
      bus.dma_dst      <= '0;
      bus.dma_len      <= '0;
      bus.map_we       <= 1'b0;
      bus.map_slot     <= '0;
      bus.map_sub      <= '0;
      bus.map_page     <= '0;
      bus.map_typ      <= '0;
      bus.map_block_id <= '0;
      bus.map_offset   <= '0;
      bus.blk_we       <= 1'b0;
      bus.blk_ref      <= '0;
      bus.blk_count    <= '0;
      bus.blk_offset   <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            idx          <= '0;
            alloc        <= '0;
            busy         <= 1'b1;
            bus.cfg_addr <= '0;
            st           <= S_FETCH;
          end
        end
        S_FETCH: st <= S_WAIT;
        S_WAIT: begin
          ent.typ <= config_typ_t'(bus.cfg_typ);
          ent.reference     <= bus.cfg_reference;
          ent.block_count   <= bus.cfg_block_count;
          ent.slot          <= bus.cfg_slot;
          ent.sub_slot      <= bus.cfg_sub_slot;
          ent.start_block   <= bus.cfg_start_block;
          ent.store_address <= bus.cfg_store_address;
          st                <= S_DECODE;
        end
        S_DECODE: begin
          bus.map_slot     <= ent.slot;
          bus.map_sub      <= ent.sub_slot;
          bus.map_page     <= ent.start_block;
          bus.map_offset   <= '0;
          bus.map_block_id <= ent.reference;
          bus.map_typ      <= cfg2slot_typ(ent.typ);
          bus.blk_ref      <= ent.reference;
          bus.blk_count    <= {2'b0, ent.block_count};
          bus.blk_offset   <= 25'(alloc) << BLOCK_SHIFT;
          if (ent.typ == CONFIG_NONE) begin
            st <= S_DONE;
          end else if (alloc_typ) begin
            if (ent.block_count == 8'd0) begin
              st <= S_NEXT;
            end else if (overflow) begin
              st <= S_ERR;
            end else begin
              bus.blk_we <= 1'b1;
              st         <= S_ALLOC;
            end
          end else if (mirror_typ) begin
            bus.map_we <= 1'b1;
            st         <= S_MAP;
          end else begin
            st <= S_NEXT;
          end
        end
        S_ALLOC: begin
          bus.blk_we <= 1'b0;
          base       <= alloc;
          alloc      <= alloc_sum[11:0];
          bus.map_we <= 1'b1;
          st         <= S_MAP;
        end
        S_MAP: begin
          if (bus.map_page == last_page) begin
            bus.map_we <= 1'b0;
            if (dma_typ) begin
              bus.dma_req <= 1'b1;
              bus.dma_src <= ent.store_address;
              bus.dma_dst <= 25'(base) << BLOCK_SHIFT;
              bus.dma_len <= 22'(ent.block_count)
                             << BLOCK_SHIFT;
              st          <= S_DMA;
            end else begin
              st <= S_NEXT;
            end
          end else begin
            bus.map_page   <= bus.map_page + 2'd1;
            bus.map_offset <= bus.map_offset + 2'd1;
          end
        end
        S_DMA: begin
          if (bus.dma_ack) begin
            bus.dma_req <= 1'b0;
            st          <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx == 4'(MAX_ENTRIES - 1)) begin
            idx <= '0;
            st  <= S_DONE;
          end else begin
            idx          <= idx + 4'd1;
            bus.cfg_addr <= idx + 4'd1;
            st           <= S_FETCH;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          st   <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          st    <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/msx_layout_sequencer.md
Name: msx_layout_sequencer

Overview:
Walks the machine-configuration table (msx_config_t entries) after a config load. Allocates SDRAM space in 16 KB blocks for each entry and schedules DDR3-to-SDRAM copies on the shared DMA engine. Fills the block_t table (per reference) and the mem_block_t slot map (per slot/sub_slot/page). Sits between the config-table BRAM, the DDR3 copy DMA and the memory-map registers; runs once per configuration and leaves the map ready before CPU reset is released.

Parameters:
MAX_ENTRIES, 16, number of config-table entries; index width is 4
SDRAM_BLOCKS, 2048, SDRAM capacity in 16 KB blocks (2048 × 16 KB = 32 MB, the full 25-bit offset range)

Ports:
clk_sys in 1 system clock
reset_n in 1 asynchronous active-low reset
start in 1 one-cycle pulse; begin sequencing
cfg_addr out 4 config-table read index
cfg_typ in 5 config_typ_t of entry; valid 1 cycle after cfg_addr
cfg_reference in 4 block reference id
cfg_block_count in 8 length in 16 KB blocks
cfg_slot in 2 target slot
cfg_sub_slot in 2 target sub-slot
cfg_start_block in 2 first page (0-3)
cfg_store_address in 28 DDR3 source byte address
dma_req out 1 copy request; held until dma_ack
dma_src out 28 DDR3 byte address
dma_dst out 25 SDRAM byte address
dma_len out 22 length in bytes
dma_ack in 1 one-cycle pulse; copy finished
map_we out 1 slot-map write strobe
map_slot out 2 slot index
map_sub out 2 sub-slot index
map_page out 2 page index
map_typ out 4 slot_typ_t
map_block_id out 4 block id
map_offset out 2 block offset
blk_we out 1 block-table write strobe
blk_ref out 4 block-table index
blk_count out 10 block count
blk_offset out 25 SDRAM byte offset
busy out 1 sequencing in progress
done out 1 sticky; table completed
error out 1 sticky; SDRAM overflow

Behaviour:
- Reset: all outputs 0. State is IDLE, entry index 0, allocation pointer `alloc` (12 bit) 0.
- States:
  - IDLE: on start, clear done/error, set idx=0 and alloc=0, go to FETCH. start while busy is ignored.
  - FETCH: drive cfg_addr=idx, go to WAIT (one-cycle table latency).
  - WAIT: go to DECODE; capture the cfg_* fields at the end of this cycle.
  - DECODE, by captured typ:
    - CONFIG_NONE: go to DONE.
    - RAM, RAM_MAPPER, BIOS, FDC, CART_A, CART_B: allocating entries.
      - block_count=0: go to NEXT.
      - alloc + block_count > SDRAM_BLOCKS: go to ERR.
      - otherwise go to ALLOC.
    - KBD_LAYOUT, ROM_MIRROR, IO_MIRROR, MIRROR: go to MAP with no allocation.
    - Any other code: go to NEXT.
  - ALLOC: one-cycle blk_we with blk_ref=reference, blk_count={2'b0,block_count}, blk_offset=alloc<<14. Record base=alloc, set alloc+=block_count, go to MAP.
  - MAP: one map_we per cycle for page p = start_block .. min(3, start_block+block_count-1); block_count=0 on a mirror type gives one write.
    - map_slot=slot, map_sub=sub_slot, map_page=p, map_block_id=reference, map_offset=p-start_block.
    - map_typ: RAM→SLOT_TYP_RAM; RAM_MAPPER→SLOT_TYP_MAPPER; BIOS and all mirror types→SLOT_TYP_ROM; FDC→SLOT_TYP_FDC; CART_A→SLOT_TYP_CART_A; CART_B→SLOT_TYP_CART_B.
    - Afterwards: BIOS/FDC/CART_A/CART_B go to DMA; all other types go to NEXT.
  - DMA: assert dma_req with dma_src=store_address, dma_dst=base<<14, dma_len=block_count<<14. Hold req and operands stable until dma_ack is sampled high, drop req in the same cycle, go to NEXT.
  - NEXT: idx+1. Wrap to 0 (idx=MAX_ENTRIES-1 done) goes to DONE; otherwise FETCH.
  - DONE: done=1, busy=0, go to IDLE.
  - ERR: error=1, done=1, busy=0, go to IDLE. Map/block writes already issued remain.
- busy=1 in every state except IDLE.
- dma_ack outside DMA is ignored. Reset mid-copy drops dma_req asynchronously; the DMA engine must tolerate this.
- start in the same cycle as DONE/ERR is ignored; a start in IDLE restarts from entry 0 and alloc 0.

Decomposition:
- Already in the shared MSX package: config_typ_t, slot_typ_t, msx_config_t, block_t, mem_block_t.
- Add to the package: BLOCK_SHIFT=14 and a function cfg2slot_typ(config_typ_t)→slot_typ_t, also used by the slot decoder.
- No sub-module: a single FSM with the page counter.

Test Plan:
- Table [BIOS ref0 cnt2 slot0 sub0 start0 src 0x100000, NONE], start → blk_we ref0 cnt2 off 0; map_we pages 0,1 offsets 0,1 typ ROM; dma_req src 0x100000 dst 0 len 0x8000; after ack, done=1.
- Table [RAM ref1 cnt4 start0, CART_A ref2 cnt1 start1 slot1] → RAM blk off 0, four map writes, no DMA; CART_A blk off 0x10000, one map write page1 offset0 typ CART_A, DMA dst 0x10000 len 0x4000.
- ROM_MIRROR ref0 slot3 sub2 start2 cnt0 → exactly one map_we page2 block_id 0, no blk_we, no dma_req.
- Allocations totalling 2040 blocks, then an entry cnt 16 → error=1, done=1, no blk_we for the overflowing entry.
- 16 entries with no NONE → idx wraps, done=1 after entry 15.
- reset_n low while dma_req is held → next edge sees all outputs 0; a later start re-runs from entry 0 with alloc=0.
